// File: rtl/delayslot_resolver_pkg.sv
// Decode-stage shared types for the delay-slot resolver.
//   ds_lane_t  : one decoded lane as seen by the delay-slot logic
//   ds_state_e : resolver FSM states
package delayslot_resolver_pkg;

   localparam int DS_ADDR_W = 32;

   typedef struct packed {
      logic                 valid;
      logic                 cf;
      logic                 likely;
      logic                 taken;
      logic [DS_ADDR_W-1:0] target;
   } ds_lane_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_DS,
      REDIRECT
   } ds_state_e;

endpackage

// File: rtl/delayslot_resolver_scan.sv
// delayslot_scan: combinational in-order lane scan for one decode group.
// Inputs : lane_valid/cf/likely/taken/target per lane, p_in (a branch from an
//          earlier group still owes its slot) and that owner's fields.
// Outputs: resolved/nullify/kill masks, end-of-group pending flag and owner
//          fields, and taken_found (a taken branch's slot was in this group).
module delayslot_scan #(
   parameter int N_ISSUE    = 2,
   parameter int ADDR_WIDTH = 32
) (
   input  logic [N_ISSUE-1:0]                 lane_valid,
   input  logic [N_ISSUE-1:0]                 lane_cf,
   input  logic [N_ISSUE-1:0]                 lane_likely,
   input  logic [N_ISSUE-1:0]                 lane_taken,
   input  logic [N_ISSUE-1:0][ADDR_WIDTH-1:0] lane_target,
   input  logic                               p_in,
   input  logic                               own_taken_in,
   input  logic                               own_likely_in,
   input  logic [ADDR_WIDTH-1:0]              own_target_in,
   output logic [N_ISSUE-1:0]                 resolved,
   output logic [N_ISSUE-1:0]                 nullify,
   output logic [N_ISSUE-1:0]                 kill,
   output logic                               p_out,
   output logic                               own_taken_out,
   output logic                               own_likely_out,
   output logic [ADDR_WIDTH-1:0]              own_target_out,
   output logic                               taken_found
);

   always_comb begin
      resolved       = '0;
      nullify        = '0;
      kill           = '0;
      taken_found    = 1'b0;
      p_out          = p_in;
      own_taken_out  = own_taken_in;
      own_likely_out = own_likely_in;
      own_target_out = own_target_in;
      for (int i = 0; i < N_ISSUE; i++) begin
         // Once a taken branch's slot has gone by, everything behind it is wrong-path.
         if (taken_found) begin
            kill[i] = 1'b1;
         end else if (lane_valid[i]) begin
            if (p_out) begin
               // A cf lane sitting in a slot never opens a new wait.
               resolved[i] = 1'b1;
               nullify[i]  = own_likely_out & ~own_taken_out;
               taken_found = own_taken_out;
               p_out       = 1'b0;
            end else if (lane_cf[i]) begin
               p_out          = 1'b1;
               own_taken_out  = lane_taken[i];
               own_likely_out = lane_likely[i];
               own_target_out = lane_target[i];
            end
         end
      end
   end

endmodule

// File: rtl/delayslot_resolver.sv
// delayslot_resolver: pairs branches with their delay slots across issue
// groups, annuls not-taken likely slots, squashes wrong-path lanes and
// requests a fetch redirect with a valid/ready handshake.
// Ports: clk/rst (sync, active-high), flush, stall, per-lane valid/cf/likely/
//        taken/target in; accept, resolved_delayslot/nullify/kill masks
//        (valid only in the fire cycle), redirect_valid/target/ready,
//        wait_delayslot (FSM in WAIT_DS).
module delayslot_resolver
   import delayslot_resolver_pkg::*;
#(
   parameter int N_ISSUE        = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter bit SUPPORT_LIKELY = 1'b1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               flush,
   input  logic                               stall,
   input  logic [N_ISSUE-1:0]                 lane_valid,
   input  logic [N_ISSUE-1:0]                 lane_cf,
   input  logic [N_ISSUE-1:0]                 lane_likely,
   input  logic [N_ISSUE-1:0]                 lane_taken,
   input  logic [N_ISSUE-1:0][ADDR_WIDTH-1:0] lane_target,
   output logic                               accept,
   output logic [N_ISSUE-1:0]                 resolved_delayslot,
   output logic [N_ISSUE-1:0]                 nullify,
   output logic [N_ISSUE-1:0]                 kill,
   output logic                               redirect_valid,
   output logic [ADDR_WIDTH-1:0]              redirect_target,
   input  logic                               redirect_ready,
   output logic                               wait_delayslot
);

   ds_state_e             state_q, state_d;
   logic                  w_taken_q, w_taken_d;
   logic                  w_likely_q, w_likely_d;
   logic [ADDR_WIDTH-1:0] w_target_q, w_target_d;
   logic [ADDR_WIDTH-1:0] redirect_target_q, redirect_target_d;

   logic                  fire;
   logic [N_ISSUE-1:0]    likely_eff;
   logic [N_ISSUE-1:0]    scan_resolved, scan_nullify, scan_kill;
   logic                  scan_p, scan_own_taken, scan_own_likely, scan_taken_found;
   logic [ADDR_WIDTH-1:0] scan_own_target;

   assign accept         = (state_q != REDIRECT);
   assign redirect_valid = (state_q == REDIRECT);
   assign wait_delayslot = (state_q == WAIT_DS);
   assign redirect_target = redirect_target_q;

   assign fire       = lane_valid[0] & accept & ~stall & ~flush;
   // Without likely support the likely bits never reach the scan or the latch.
   assign likely_eff = SUPPORT_LIKELY ? lane_likely : '0;

   delayslot_scan #(
      .N_ISSUE    (N_ISSUE),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scan (
      .lane_valid     (lane_valid),
      .lane_cf        (lane_cf),
      .lane_likely    (likely_eff),
      .lane_taken     (lane_taken),
      .lane_target    (lane_target),
      .p_in           (state_q == WAIT_DS),
      .own_taken_in   (w_taken_q),
      .own_likely_in  (w_likely_q),
      .own_target_in  (w_target_q),
      .resolved       (scan_resolved),
      .nullify        (scan_nullify),
      .kill           (scan_kill),
      .p_out          (scan_p),
      .own_taken_out  (scan_own_taken),
      .own_likely_out (scan_own_likely),
      .own_target_out (scan_own_target),
      .taken_found    (scan_taken_found)
   );

   assign resolved_delayslot = fire ? scan_resolved : '0;
   assign nullify            = fire ? scan_nullify  : '0;
   assign kill               = fire ? scan_kill     : '0;

   always_comb begin
      state_d           = state_q;
      w_taken_d         = w_taken_q;
      w_likely_d        = w_likely_q;
      w_target_d        = w_target_q;
      redirect_target_d = redirect_target_q;
      if (flush) begin
         // Flush drops any pending wait or redirect, even a same-cycle handshake.
         state_d           = IDLE;
         w_taken_d         = 1'b0;
         w_likely_d        = 1'b0;
         w_target_d        = '0;
         redirect_target_d = '0;
      end else if (state_q == REDIRECT) begin
         if (redirect_ready) begin
            state_d           = IDLE;
            redirect_target_d = '0;
         end
      end else if (fire) begin
         w_taken_d  = 1'b0;
         w_likely_d = 1'b0;
         w_target_d = '0;
         if (scan_taken_found) begin
            state_d           = REDIRECT;
            redirect_target_d = scan_own_target;
         end else if (scan_p) begin
            // Branch in the last valid lane: its slot arrives with a later group.
            state_d    = WAIT_DS;
            w_taken_d  = scan_own_taken;
            w_likely_d = scan_own_likely;
            w_target_d = scan_own_target;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= IDLE;
         w_taken_q         <= 1'b0;
         w_likely_q        <= 1'b0;
         w_target_q        <= '0;
         redirect_target_q <= '0;
      end else begin
         state_q           <= state_d;
         w_taken_q         <= w_taken_d;
         w_likely_q        <= w_likely_d;
         w_target_q        <= w_target_d;
         redirect_target_q <= redirect_target_d;
      end
   end

endmodule

// File: tb/tb_delayslot_resolver.sv
module tb_delayslot_resolver;

   logic clk = 1'b0;
   logic rst, flush, stall, ready;
   logic [3:0]       valid, cf, likely, taken;
   logic [3:0][31:0] tgt;

   always #5 clk = ~clk;

   // dut2: 2 lanes, likely supported. dut4: 4 lanes, likely disabled.
   logic             acc2, rv2, wd2;
   logic [1:0]       rs2, nl2, kl2;
   logic [31:0]      rt2;
   logic             acc4, rv4, wd4;
   logic [3:0]       rs4, nl4, kl4;
   logic [31:0]      rt4;

   delayslot_resolver #(.N_ISSUE(2), .ADDR_WIDTH(32), .SUPPORT_LIKELY(1'b1)) dut2 (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .lane_valid(valid[1:0]), .lane_cf(cf[1:0]), .lane_likely(likely[1:0]),
      .lane_taken(taken[1:0]), .lane_target(tgt[1:0]),
      .accept(acc2), .resolved_delayslot(rs2), .nullify(nl2), .kill(kl2),
      .redirect_valid(rv2), .redirect_target(rt2), .redirect_ready(ready),
      .wait_delayslot(wd2)
   );

   delayslot_resolver #(.N_ISSUE(4), .ADDR_WIDTH(32), .SUPPORT_LIKELY(1'b0)) dut4 (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .lane_valid(valid), .lane_cf(cf), .lane_likely(likely),
      .lane_taken(taken), .lane_target(tgt),
      .accept(acc4), .resolved_delayslot(rs4), .nullify(nl4), .kill(kl4),
      .redirect_valid(rv4), .redirect_target(rt4), .redirect_ready(ready),
      .wait_delayslot(wd4)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model state per instance: 0 = no pending branch,
   // 1 = waiting for a slot, 2 = redirect outstanding.
   int          m_state[2];
   logic        m_wt[2], m_wl[2];
   logic [31:0] m_wtgt[2], m_rtgt[2];
   int          n_state[2];
   logic        n_wt[2], n_wl[2];
   logic [31:0] n_wtgt[2], n_rtgt[2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic grp(input logic [3:0] v, input logic [3:0] c, input logic [3:0] l,
                      input logic [3:0] t);
      valid = v; cf = c; likely = l; taken = t;
      for (int i = 0; i < 4; i++) tgt[i] = $urandom;
   endtask

   // Expected group result: each branch's slot is the lane right after it
   // (or lane 0 of the next group when it was the last valid lane).
   task automatic model(input int k);
      int          n, slot;
      logic        sl, fire, pend, tf, ot, ol;
      logic [31:0] otg;
      logic [3:0]  res, nul, kil, o_res, o_nul, o_kil;
      logic        o_acc, o_rv, o_wd;
      logic [31:0] o_rt;
      n    = (k == 0) ? 2 : 4;
      sl   = (k == 0);
      fire = valid[0] && m_state[k] != 2 && !stall && !flush;
      res = '0; nul = '0; kil = '0; tf = 1'b0;
      pend = (m_state[k] == 1);
      ot = m_wt[k]; ol = m_wl[k]; otg = m_wtgt[k];
      slot = pend ? 0 : -1;
      if (fire) begin
         for (int i = 0; i < n; i++) begin
            if (tf || !valid[i]) continue;
            if (i == slot) begin
               res[i] = 1'b1;
               nul[i] = ol & ~ot;
               pend   = 1'b0;
               tf     = ot;
            end else if (cf[i]) begin
               slot = i + 1;
               pend = 1'b1;
               ot = taken[i]; ol = sl & likely[i]; otg = tgt[i];
            end
         end
         if (tf) for (int j = slot + 1; j < n; j++) kil[j] = 1'b1;
      end
      if (k == 0) begin
         o_res = {2'b00, rs2}; o_nul = {2'b00, nl2}; o_kil = {2'b00, kl2};
         o_acc = acc2; o_rv = rv2; o_wd = wd2; o_rt = rt2;
      end else begin
         o_res = rs4; o_nul = nl4; o_kil = kl4;
         o_acc = acc4; o_rv = rv4; o_wd = wd4; o_rt = rt4;
      end
      chk($sformatf("d%0d_resolved", k), 64'(o_res), 64'(res));
      chk($sformatf("d%0d_nullify", k),  64'(o_nul), 64'(nul));
      chk($sformatf("d%0d_kill", k),     64'(o_kil), 64'(kil));
      chk($sformatf("d%0d_accept", k),   64'(o_acc), 64'(m_state[k] != 2));
      chk($sformatf("d%0d_rvalid", k),   64'(o_rv),  64'(m_state[k] == 2));
      chk($sformatf("d%0d_rtarget", k),  64'(o_rt),  64'(m_rtgt[k]));
      chk($sformatf("d%0d_wait", k),     64'(o_wd),  64'(m_state[k] == 1));
      n_state[k] = m_state[k]; n_wt[k] = m_wt[k]; n_wl[k] = m_wl[k];
      n_wtgt[k] = m_wtgt[k]; n_rtgt[k] = m_rtgt[k];
      if (flush) begin
         n_state[k] = 0; n_wt[k] = 0; n_wl[k] = 0; n_wtgt[k] = 0; n_rtgt[k] = 0;
      end else if (m_state[k] == 2) begin
         if (ready) begin n_state[k] = 0; n_rtgt[k] = 0; end
      end else if (fire) begin
         n_wt[k] = 0; n_wl[k] = 0; n_wtgt[k] = 0;
         if (tf) begin
            n_state[k] = 2; n_rtgt[k] = otg;
         end else if (pend) begin
            n_state[k] = 1; n_wt[k] = ot; n_wl[k] = ol; n_wtgt[k] = otg;
         end else begin
            n_state[k] = 0;
         end
      end
   endtask

   task automatic check();
      @(negedge clk);
      if (!rst) begin
         model(0);
         model(1);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_state[k] = 0; m_wt[k] = 0; m_wl[k] = 0; m_wtgt[k] = 0; m_rtgt[k] = 0;
         end else begin
            m_state[k] = n_state[k]; m_wt[k] = n_wt[k]; m_wl[k] = n_wl[k];
            m_wtgt[k] = n_wtgt[k]; m_rtgt[k] = n_rtgt[k];
         end
      end
      #1;
   endtask

   initial begin
      int nv;
      rst = 1'b1; flush = 1'b0; stall = 1'b0; ready = 1'b0;
      grp(4'b0000, 4'b0000, 4'b0000, 4'b0000);
      repeat (2) begin check(); adv(); end
      rst = 1'b0;

      // Reset state
      check();
      chk("rst_accept", 64'(acc2), 64'(1)); chk("rst_rvalid", 64'(rv2), 64'(0));
      chk("rst_rtarget", 64'(rt2), 64'(0)); chk("rst_wait", 64'(wd2), 64'(0));
      adv();

      // Taken branch lane 0, slot lane 1; redirect held with ready low
      grp(4'b0011, 4'b0001, 4'b0000, 4'b0001); tgt[0] = 32'h8000_1000;
      check(); chk("t1_res", 64'(rs2), 64'(2'b10)); chk("t1_kill", 64'(kl2), 64'(0)); adv();
      grp(4'b0000, 4'b0000, 4'b0000, 4'b0000); ready = 1'b0;
      repeat (4) begin
         check();
         chk("t1_rvalid", 64'(rv2), 64'(1)); chk("t1_rtarget", 64'(rt2), 64'(32'h8000_1000));
         chk("t1_accept", 64'(acc2), 64'(0));
         adv();
      end
      ready = 1'b1; check(); adv(); ready = 1'b0;
      check(); chk("t1_accept_back", 64'(acc2), 64'(1)); chk("t1_rv_low", 64'(rv2), 64'(0)); adv();

      // Not-taken branch in last lane, slot after 3 stalls
      grp(4'b0011, 4'b0010, 4'b0000, 4'b0000); check(); adv();
      stall = 1'b1; grp(4'b0011, 4'b0000, 4'b0000, 4'b0000);
      repeat (3) begin
         check(); chk("t2_wait", 64'(wd2), 64'(1)); chk("t2_res_stall", 64'(rs2), 64'(0)); adv();
      end
      stall = 1'b0; check(); chk("t2_res", 64'(rs2), 64'(2'b01)); adv();
      grp(4'b0000, 4'b0000, 4'b0000, 4'b0000);
      check(); chk("t2_idle", 64'(wd2), 64'(0)); adv();

      // 4-lane taken jump in lane 0
      grp(4'b1111, 4'b0001, 4'b0000, 4'b0001);
      check(); chk("t3_res4", 64'(rs4), 64'(4'b0010)); chk("t3_kill4", 64'(kl4), 64'(4'b1100)); adv();
      grp(4'b0000, 4'b0000, 4'b0000, 4'b0000); ready = 1'b1; check(); adv(); ready = 1'b0;

      // Likely not-taken in lane 0
      grp(4'b0011, 4'b0001, 4'b0001, 4'b0000);
      check(); chk("t4_null2", 64'(nl2), 64'(2'b10)); chk("t4_null4", 64'(nl4), 64'(0)); adv();
      grp(4'b0000, 4'b0000, 4'b0000, 4'b0000);
      check(); chk("t4_no_redirect", 64'(rv2), 64'(0)); adv();

      // Flush while waiting for a slot
      grp(4'b0011, 4'b0010, 4'b0000, 4'b0000); check(); adv();
      grp(4'b0000, 4'b0000, 4'b0000, 4'b0000); flush = 1'b1; check(); adv(); flush = 1'b0;
      check(); chk("t5_wait", 64'(wd2), 64'(0)); chk("t5_rvalid", 64'(rv2), 64'(0)); adv();
      grp(4'b0011, 4'b0000, 4'b0000, 4'b0000);
      check(); chk("t5_res", 64'(rs2), 64'(0)); adv();

      // Flush during redirect, same cycle as ready
      grp(4'b0011, 4'b0001, 4'b0000, 4'b0001); check(); adv();
      grp(4'b0000, 4'b0000, 4'b0000, 4'b0000); ready = 1'b1; flush = 1'b1;
      check(); chk("t6_rv_before", 64'(rv2), 64'(1)); adv();
      flush = 1'b0; ready = 1'b0;
      check(); chk("t6_rvalid", 64'(rv2), 64'(0)); chk("t6_accept", 64'(acc2), 64'(1)); adv();
      grp(4'b0011, 4'b0000, 4'b0000, 4'b0000);
      check(); chk("t6_res", 64'(rs2), 64'(0)); adv();

      // Randomized groups
      repeat (600) begin
         nv = $urandom_range(0, 4);
         grp(4'b1111 >> (4 - nv), 4'($urandom), 4'($urandom), 4'($urandom));
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 19) == 0);
         ready = ($urandom_range(0, 1) == 1);
         check(); adv();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
